// File: rtl/wall_datapath_pkg.sv
// Shared definitions for the wall controller and its datapath: state codes,
// draw-engine states, colours and screen geometry.
package wall_datapath_pkg;

    typedef enum logic [2:0] {
        W_READY = 3'b000,
        W_MOVE  = 3'b001,
        W_STOP  = 3'b011,
        W_DRAW  = 3'b111
    } wall_state_e;

    typedef enum logic [1:0] {
        ENG_IDLE,
        ENG_ERASE,
        ENG_PAINT,
        ENG_DONE
    } eng_state_e;

    localparam logic [2:0] BLACK = 3'b000;
    localparam logic [2:0] WHITE = 3'b111;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;

    // Saturating subtract used when the wall steps left.
    function automatic logic [7:0] sat_sub(input logic [7:0] a, input logic [7:0] b);
        return (a > b) ? (a - b) : 8'd0;
    endfunction

endpackage

// File: rtl/wall_datapath_rect_scanner.sv
// Rectangle scanner: walks RW x RH pixels from a latched base, x inner loop
// then y, one pixel per cycle. A start on the last pixel restarts seamlessly.
module wall_datapath_rect_scanner #(
    parameter int RW = 8,
    parameter int RH = 40
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       start,
    input  logic [7:0] base_x,
    input  logic [6:0] base_y,
    output logic       valid,
    output logic       last,
    output logic [8:0] px,
    output logic [6:0] py
);
    import wall_datapath_pkg::*;

    logic [7:0] cx;
    logic [6:0] cy;
    logic [7:0] base_x_reg;
    logic [6:0] base_y_reg;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            valid      <= 1'b0;
            cx         <= 8'd0;
            cy         <= 7'd0;
            base_x_reg <= 8'd0;
            base_y_reg <= 7'd0;
        end else if (start) begin
            valid      <= 1'b1;
            cx         <= 8'd0;
            cy         <= 7'd0;
            base_x_reg <= base_x;
            base_y_reg <= base_y;
        end else if (valid) begin
            if (cx == 8'(RW - 1)) begin
                cx <= 8'd0;
                if (cy == 7'(RH - 1)) begin
                    cy    <= 7'd0;
                    valid <= 1'b0;
                end else begin
                    cy <= cy + 7'd1;
                end
            end else begin
                cx <= cx + 8'd1;
            end
        end
    end

    assign last = valid && (cx == 8'(RW - 1)) && (cy == 7'(RH - 1));
    // Nine bits on x so pixels past the right screen edge can be clipped.
    assign px   = {1'b0, base_x_reg} + {1'b0, cx};
    assign py   = base_y_reg + cy;

endmodule

// File: rtl/wall_datapath.sv
// Wall datapath: moves the wall on frame ticks, reports touches and redraws
// the wall via the VGA pixel port. WALL_SPEEDUP_EN makes each STOP speed it up.
module wall_datapath #(
    parameter int         SCREEN_W    = wall_datapath_pkg::SCREEN_W,
    parameter int         WALL_W      = 8,
    parameter int         WALL_H      = 40,
    parameter int         WALL_Y      = 80,
    parameter int         START_X     = 152,
    parameter int         PLAYER_SZ   = 8,
    parameter int         STEP        = 1,
    parameter int         FRAME_DIV   = 833333,
    parameter logic [2:0] WALL_COLOUR = wall_datapath_pkg::WHITE
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [2:0] state,
    input  logic [7:0] player_x,
    input  logic [6:0] player_y,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] colour,
    output logic       plot,
    output logic       touched,
    output logic       draw_done,
    output logic [7:0] wall_x
);
    import wall_datapath_pkg::*;

    localparam int CNT_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

    logic [CNT_W-1:0] frame_cnt;
    logic             frame_tick;
    logic             tick_pending, tick_pending_next;
    logic [7:0]       wall_x_reg, wall_x_next;
    logic [7:0]       drawn_x, paint_x, step_val, scan_base;
    eng_state_e       eng_reg, eng_next;
    logic             scan_start, scan_valid, scan_last, accept;
    logic             touched_reg, touch_next;
    logic [8:0]       scan_px;
    logic [6:0]       scan_py;
    logic [8:0]       player_r, wall_r;
    logic [7:0]       player_b;

    assign frame_tick = (frame_cnt == CNT_W'(FRAME_DIV - 1));

`ifdef WALL_SPEEDUP_EN
    logic [3:0] step_reg;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            step_reg <= 4'(STEP);
        else if (state == W_STOP && step_reg != 4'hF)
            step_reg <= step_reg + 4'd1;
    end

    assign step_val = {4'b0000, step_reg};
`else
    assign step_val = 8'(STEP);
`endif

    // Wall motion; a tick seen while the engine is busy stays pending.
    always_comb begin
        wall_x_next       = wall_x_reg;
        tick_pending_next = tick_pending;
        case (state)
            W_MOVE: begin
                if (tick_pending && eng_reg == ENG_IDLE) begin
                    wall_x_next       = sat_sub(wall_x_reg, step_val);
                    tick_pending_next = 1'b0;
                end
            end
            W_STOP: begin
                wall_x_next       = 8'(START_X);
                tick_pending_next = 1'b0;
            end
            W_DRAW: ;
            default: tick_pending_next = 1'b0;
        endcase
        if (frame_tick)
            tick_pending_next = 1'b1;
    end

    always_comb begin
        eng_next   = eng_reg;
        scan_start = 1'b0;
        scan_base  = drawn_x;
        accept     = 1'b0;
        case (eng_reg)
            ENG_IDLE: begin
                if (state == W_DRAW) begin
                    accept     = 1'b1;
                    scan_start = 1'b1;
                    eng_next   = ENG_ERASE;
                end
            end
            ENG_ERASE: begin
                if (scan_last) begin
                    scan_start = 1'b1;
                    scan_base  = paint_x;
                    eng_next   = ENG_PAINT;
                end
            end
            ENG_PAINT: begin
                if (scan_last)
                    eng_next = ENG_DONE;
            end
            default: eng_next = ENG_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            frame_cnt    <= '0;
            tick_pending <= 1'b0;
            wall_x_reg   <= 8'(START_X);
            drawn_x      <= 8'(START_X);
            paint_x      <= 8'(START_X);
            eng_reg      <= ENG_IDLE;
            touched_reg  <= 1'b0;
        end else begin
            frame_cnt    <= frame_tick ? '0 : frame_cnt + 1'b1;
            tick_pending <= tick_pending_next;
            wall_x_reg   <= wall_x_next;
            eng_reg      <= eng_next;
            touched_reg  <= touch_next;
            if (accept)
                paint_x <= wall_x_reg;
            if (eng_reg == ENG_PAINT && scan_last)
                drawn_x <= paint_x;
        end
    end

    wall_datapath_rect_scanner #(
        .RW(WALL_W),
        .RH(WALL_H)
    ) u_rect_scanner (
        .clk    (clk),
        .resetn (resetn),
        .start  (scan_start),
        .base_x (scan_base),
        .base_y (7'(WALL_Y)),
        .valid  (scan_valid),
        .last   (scan_last),
        .px     (scan_px),
        .py     (scan_py)
    );

    // Widened sums so right/bottom edges near the screen limit do not wrap.
    assign player_r   = {1'b0, player_x} + 9'(PLAYER_SZ);
    assign wall_r     = {1'b0, wall_x_reg} + 9'(WALL_W);
    assign player_b   = {1'b0, player_y} + 8'(PLAYER_SZ);
    assign touch_next = (wall_x_reg == 8'd0) ||
                        (({1'b0, wall_x_reg} < player_r) && ({1'b0, player_x} < wall_r) &&
                         (8'(WALL_Y) < player_b) && ({1'b0, player_y} < 8'(WALL_Y + WALL_H)));

    assign plot      = scan_valid && (scan_px < 9'(SCREEN_W));
    assign vga_x     = scan_valid ? scan_px[7:0] : 8'd0;
    assign vga_y     = scan_valid ? scan_py : 7'd0;
    assign colour    = (scan_valid && eng_reg == ENG_PAINT) ? WALL_COLOUR : BLACK;
    assign touched   = touched_reg;
    assign draw_done = (eng_reg == ENG_DONE);
    assign wall_x    = wall_x_reg;

endmodule

// File: doc/wall_datapath.md
Name: wall_datapath

Overview:
- Responder/datapath for the wall controller FSM in the VGA game.
- Consumes the 3-bit wall state code (READY/MOVE/STOP/DRAW) and advances the wall position on frame ticks.
- Produces `touched` back to the controller.
- On each DRAW request, erases the old wall rectangle and paints the new one through the VGA pixel-write port, then pulses `draw_done`.

Parameters:
- SCREEN_W, 160, screen width in pixels (x range 0..159)
- WALL_W, 8, wall rectangle width
- WALL_H, 40, wall rectangle height
- WALL_Y, 80, fixed top row of the wall
- START_X, 152, wall x reload value after reset/STOP
- PLAYER_SZ, 8, player square side length, used for collision
- STEP, 1, pixels moved left per frame tick
- FRAME_DIV, 833333, clk cycles per frame tick (50 MHz / 60)
- WALL_COLOUR, 3'b111, paint colour; erase colour fixed at 3'b000

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- state  in  3  controller state: 000 READY, 001 MOVE, 011 STOP, 111 DRAW
- player_x  in  8  player top-left x
- player_y  in  7  player top-left y
- vga_x  out  8  pixel x to VGA adapter
- vga_y  out  7  pixel y to VGA adapter
- colour  out  3  pixel colour
- plot  out  1  pixel write enable
- touched  out  1  collision/left-edge flag to controller
- draw_done  out  1  one-cycle pulse, redraw finished
- wall_x  out  8  current wall left x

Behaviour:
- Reset (async, resetn=0), outputs take these values immediately:
  - wall_x=START_X; drawn_x=START_X; engine IDLE
  - plot=0, draw_done=0, touched=0, vga_x=0, vga_y=0, colour=0
  - frame counter=0, tick_pending=0
  - A reset mid-draw aborts the draw with no further plots.
- Frame counter:
  - Counts 0..FRAME_DIV-1 and wraps.
  - The wrap cycle is a tick.
  - A tick sets tick_pending.
- State actions (any undefined state code is treated as READY):
  - READY: hold wall_x; clear tick_pending.
  - MOVE with tick_pending and engine IDLE: wall_x <= (wall_x > STEP) ? wall_x-STEP : 0; clear tick_pending. While the engine is busy the pending tick is held, not lost; wall_x is frozen during drawing.
  - STOP: wall_x <= START_X; clear tick_pending.
  - DRAW with engine IDLE: accept request; latch erase_x=drawn_x and paint_x=wall_x. DRAW while engine busy is ignored; no restart.
- Draw engine states: IDLE -> ERASE -> PAINT -> DONE -> IDLE.
  - ERASE and PAINT each scan WALL_W x WALL_H pixels, one per cycle, x inner loop then y.
  - Coordinates: vga_x = base_x + cx, vga_y = WALL_Y + cy.
  - ERASE uses colour 000 at erase_x; PAINT uses WALL_COLOUR at paint_x.
  - Pixels with base_x+cx >= SCREEN_W are scanned but plot=0 (clipping); the cycle count is unchanged.
  - ERASE->PAINT is seamless; no idle cycle.
  - After the last PAINT pixel: drawn_x <= paint_x; DONE drives draw_done=1 for exactly one cycle.
- Latency: request accepted in cycle N; first plot in N+1; plot window is 2*WALL_W*WALL_H cycles (640 at defaults); draw_done in N+641.
- touched: registered, level, updated every cycle from the current wall_x. It is 1 iff either:
  - wall_x==0, or
  - the rectangles overlap: wall_x < player_x+PLAYER_SZ, player_x < wall_x+WALL_W, WALL_Y < player_y+PLAYER_SZ, and player_y < WALL_Y+WALL_H.
- Arithmetic widths:
  - Overlap sums are computed at 9 bits (x) and 8 bits (y); no wrap.
  - Subtraction in MOVE saturates at 0.

Optional Feature:
- Macro: WALL_SPEEDUP_EN.
- Defined: an internal 4-bit step register (reset=STEP) replaces STEP in MOVE. Each STOP increments the step register, saturating at 15. The left-edge condition uses the current step.
- Undefined: step is constant STEP; no step register exists.

Decomposition:
- Shared package:
  - Wall state encodings W_READY=3'b000, W_MOVE=3'b001, W_STOP=3'b011, W_DRAW=3'b111, shared with the wall controller.
  - Colour constants BLACK=3'b000, WHITE=3'b111.
  - Screen dimensions SCREEN_W=160, SCREEN_H=120.
- One sub-module, rect_scanner:
  - Inputs: start, base_x, base_y.
  - Generates cx/cy counters, valid and last over WALL_W x WALL_H.
  - Instanced once and reused for both ERASE and PAINT.

Test Plan:
- Reset then one DRAW, defaults -> first 320 plots at x 152..159 / y 80..119 with colour 000, next 320 with colour 111; draw_done pulses exactly 641 cycles after accept; wall_x=152.
- MOVE held with FRAME_DIV=4, wall_x=152 -> wall_x=151 after the first tick and 150 after the second; DRAW then erases at x=152 and paints at x=150.
- MOVE with player_x=0, player_y=90, wall_x=8 -> touched=1 at wall_x=7; STOP -> wall_x=152, touched=0 next cycle.
- MOVE tick arriving during ERASE -> wall_x unchanged until draw_done, then it decrements exactly once; a second DRAW issued mid-draw produces no extra plots.
- resetn asserted low at pixel 100 of PAINT -> plot=0 immediately; wall_x=152; the next DRAW erases at x=152.
- WALL_SPEEDUP_EN defined: three STOPs, then MOVE -> wall_x decreases by 4 per tick from 152 (148, 144, ...).
